// File: rtl/hiscore_pkg.sv
// Shared types and constants for the hiscore engine and its work-RAM port mux.
package hiscore_pkg;
   typedef enum logic [2:0] {
      CPU_OWN    = 3'd0,
      PAUSE_WAIT = 3'd1,
      SETTLE     = 3'd2,
      HS_OWN     = 3'd3,
      RELEASE    = 3'd4
   } mux_state_t;

   localparam int SETTLE_W  = 4;
   localparam int TIMEOUT_W = 16;

   // ioctl download indices understood by the hiscore engine
   localparam logic [7:0] IOCTL_INDEX_CONFIG = 8'd3;
   localparam logic [7:0] IOCTL_INDEX_DUMP   = 8'd4;
endpackage

// File: rtl/hs_down_counter.sv
// Loadable down counter with a zero flag; holds at zero instead of wrapping.
module hs_down_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         dec,
   output logic         zero
);
   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_value;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);
endmodule

// File: rtl/hiscore_ram_mux.sv
// Hands the game work-RAM port between the CPU and the hiscore engine via a halt handshake.
// Optional halt-acknowledge watchdog and hs_timeout port: define HISCORE_MUX_TIMEOUT_EN.
module hiscore_ram_mux
   import hiscore_pkg::*;
#(
   parameter int ADDRESSWIDTH   = 10,
   parameter int DATAWIDTH      = 8,
   parameter int SETTLE_CYCLES  = 2,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    hs_pause_req,
   input  logic [ADDRESSWIDTH-1:0] hs_address,
   input  logic [DATAWIDTH-1:0]    hs_wdata,
   input  logic                    hs_write,
   output logic [DATAWIDTH-1:0]    hs_rdata,
   output logic                    hs_grant,
   output logic                    hs_write_dropped,
`ifdef HISCORE_MUX_TIMEOUT_EN
   output logic                    hs_timeout,
`endif
   input  logic [ADDRESSWIDTH-1:0] cpu_address,
   input  logic [DATAWIDTH-1:0]    cpu_wdata,
   input  logic                    cpu_cs,
   input  logic                    cpu_write,
   input  logic                    cpu_idle,
   output logic                    cpu_pause,
   output logic [DATAWIDTH-1:0]    cpu_rdata,
   output logic [ADDRESSWIDTH-1:0] ram_address,
   output logic [DATAWIDTH-1:0]    ram_wdata,
   output logic                    ram_write,
   input  logic [DATAWIDTH-1:0]    ram_rdata
);
   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
      $fatal(1, "hiscore_ram_mux: SETTLE_CYCLES must be 1..15, TIMEOUT_CYCLES 1..65535");
   end

   mux_state_t             state_q, state_d;
   logic                   settle_load, settle_dec, settle_zero;
   logic                   cpu_pause_q, cpu_pause_d;
   logic                   hs_grant_q, hs_grant_d;
   logic                   hs_write_dropped_q, hs_write_dropped_d;
   logic [DATAWIDTH-1:0]   hs_rdata_q, hs_rdata_d;
   logic [DATAWIDTH-1:0]   cpu_rdata_q, cpu_rdata_d;

   hs_down_counter #(.W(SETTLE_W)) u_settle (
      .clk        (clk),
      .reset      (reset),
      .load       (settle_load),
      .load_value (SETTLE_LOAD),
      .dec        (settle_dec),
      .zero       (settle_zero)
   );

`ifdef HISCORE_MUX_TIMEOUT_EN
   localparam logic [TIMEOUT_W-1:0] TIMEOUT_LOAD = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
   logic wd_load, wd_zero, tmo_fire;
   logic hs_timeout_q, hs_timeout_d;

   // Reloaded on every entry so an aborted pause never shortens the next wait
   assign wd_load = (state_d == PAUSE_WAIT) && (state_q != PAUSE_WAIT);

   hs_down_counter #(.W(TIMEOUT_W)) u_watchdog (
      .clk        (clk),
      .reset      (reset),
      .load       (wd_load),
      .load_value (TIMEOUT_LOAD),
      .dec        (state_q == PAUSE_WAIT),
      .zero       (wd_zero)
   );

   assign hs_timeout_d = hs_timeout_q | tmo_fire;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hs_timeout_q <= 1'b0;
      end else begin
         hs_timeout_q <= hs_timeout_d;
      end
   end

   assign hs_timeout = hs_timeout_q;
`endif

   always_comb begin
      state_d     = state_q;
      settle_load = 1'b0;
      settle_dec  = 1'b0;
`ifdef HISCORE_MUX_TIMEOUT_EN
      tmo_fire    = 1'b0;
`endif
      case (state_q)
         CPU_OWN: begin
            if (hs_pause_req) state_d = PAUSE_WAIT;
         end
         PAUSE_WAIT: begin
            if (!hs_pause_req) begin
               state_d = CPU_OWN;
            end else if (cpu_idle) begin
               state_d     = SETTLE;
               settle_load = 1'b1;
            end
`ifdef HISCORE_MUX_TIMEOUT_EN
            else if (wd_zero) begin
               state_d     = SETTLE;
               settle_load = 1'b1;
               tmo_fire    = 1'b1;
            end
`endif
         end
         SETTLE: begin
            if (!hs_pause_req) begin
               state_d = RELEASE;
            end else if (settle_zero) begin
               state_d = HS_OWN;
            end else begin
               settle_dec = 1'b1;
            end
         end
         HS_OWN: begin
            if (!hs_pause_req) state_d = RELEASE;
         end
         RELEASE: state_d = CPU_OWN;
         default: state_d = CPU_OWN;
      endcase
   end

   // The CPU may still write while it winds down in PAUSE_WAIT; nobody writes in SETTLE or RELEASE
   always_comb begin
      ram_address = cpu_address;
      ram_wdata   = cpu_wdata;
      ram_write   = 1'b0;
      case (state_q)
         CPU_OWN, PAUSE_WAIT: ram_write = cpu_cs & cpu_write;
         SETTLE: begin
            ram_address = hs_address;
            ram_wdata   = hs_wdata;
         end
         HS_OWN: begin
            ram_address = hs_address;
            ram_wdata   = hs_wdata;
            ram_write   = hs_write;
         end
         default: ;
      endcase
   end

   always_comb begin
      cpu_pause_d        = (state_d != CPU_OWN);
      hs_grant_d         = (state_d == HS_OWN);
      hs_rdata_d         = (state_q == HS_OWN) ? ram_rdata : hs_rdata_q;
      cpu_rdata_d        = (state_q == CPU_OWN) ? ram_rdata : cpu_rdata_q;
      hs_write_dropped_d = hs_write_dropped_q | (hs_write && (state_q != HS_OWN));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q            <= CPU_OWN;
         cpu_pause_q        <= 1'b0;
         hs_grant_q         <= 1'b0;
         hs_write_dropped_q <= 1'b0;
         hs_rdata_q         <= '0;
         cpu_rdata_q        <= '0;
      end else begin
         state_q            <= state_d;
         cpu_pause_q        <= cpu_pause_d;
         hs_grant_q         <= hs_grant_d;
         hs_write_dropped_q <= hs_write_dropped_d;
         hs_rdata_q         <= hs_rdata_d;
         cpu_rdata_q        <= cpu_rdata_d;
      end
   end

   assign cpu_pause        = cpu_pause_q;
   assign hs_grant         = hs_grant_q;
   assign hs_write_dropped = hs_write_dropped_q;
   assign hs_rdata         = hs_rdata_q;
   assign cpu_rdata        = cpu_rdata_q;
endmodule

// File: tb/tb_hiscore_ram_mux.sv
// Self-checking bench for hiscore_ram_mux with a behavioural RAM image model.
module tb_hiscore_ram_mux;
   localparam int AW     = 10;
   localparam int DW     = 8;
   localparam int SETTLE = 2;
`ifdef HISCORE_MUX_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 65535;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          hs_pause_req, hs_write, cpu_cs, cpu_write, cpu_idle;
   logic [AW-1:0] hs_address, cpu_address, ram_address;
   logic [DW-1:0] hs_wdata, cpu_wdata, ram_wdata, ram_rdata, hs_rdata, cpu_rdata;
   logic          hs_grant, hs_write_dropped, cpu_pause, ram_write;
`ifdef HISCORE_MUX_TIMEOUT_EN
   logic          hs_timeout;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] mem     [0:1023];
   logic [DW-1:0] ref_mem [0:1023];
   logic [DW-1:0] rd_exp  [0:63];
   logic [DW-1:0] frozen_exp;
   logic          tmo_seen = 1'b0;
   logic          tb_load;
   logic [AW-1:0] tb_load_addr;
   logic [DW-1:0] tb_load_data;

   always #5 clk = ~clk;

   hiscore_ram_mux #(
      .ADDRESSWIDTH(AW), .DATAWIDTH(DW), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .reset(reset),
      .hs_pause_req(hs_pause_req), .hs_address(hs_address), .hs_wdata(hs_wdata),
      .hs_write(hs_write), .hs_rdata(hs_rdata), .hs_grant(hs_grant),
      .hs_write_dropped(hs_write_dropped),
`ifdef HISCORE_MUX_TIMEOUT_EN
      .hs_timeout(hs_timeout),
`endif
      .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_cs(cpu_cs),
      .cpu_write(cpu_write), .cpu_idle(cpu_idle), .cpu_pause(cpu_pause),
      .cpu_rdata(cpu_rdata), .ram_address(ram_address), .ram_wdata(ram_wdata),
      .ram_write(ram_write), .ram_rdata(ram_rdata)
   );

   // Game work RAM: synchronous write, one-cycle registered read (old data on collision)
   always @(posedge clk) begin
      if (tb_load) mem[tb_load_addr] <= tb_load_data;
      else if (ram_write) mem[ram_address] <= ram_wdata;
      ram_rdata <= mem[ram_address];
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; hs_pause_req = 1'b0; hs_write = 1'b0; hs_address = '0; hs_wdata = '0;
      cpu_cs = 1'b0; cpu_write = 1'b0; cpu_idle = 1'b0; cpu_address = '0; cpu_wdata = '0;
      tb_load = 1'b0; tb_load_addr = '0; tb_load_data = '0;
      #2;
      n_checks++; if ({cpu_pause, hs_grant, hs_write_dropped, ram_write} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b expected 0000", {cpu_pause, hs_grant, hs_write_dropped, ram_write}); end
      n_checks++; if (hs_rdata !== 8'h00 || cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got %h/%h expected 00/00", hs_rdata, cpu_rdata); end
      hs_pause_req = 1'b1; hs_write = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         next_cycle();
         tb_load = 1'b1; tb_load_addr = AW'(i);
         tb_load_data = (i == 'h043) ? 8'h5A : (i == 'h044) ? 8'h11 : DW'($urandom);
         ref_mem[i] = tb_load_data;
      end
      next_cycle();
      tb_load = 1'b0;
      #1;
      n_checks++; if (cpu_pause !== 1'b0 || hs_write_dropped !== 1'b0) begin n_fail++; $display("FAIL reset_held got pause=%b dropped=%b expected 0 0", cpu_pause, hs_write_dropped); end
      hs_pause_req = 1'b0; hs_write = 1'b0;
      next_cycle();
      reset = 1'b0;
      next_cycle();
      n_checks++; if (cpu_pause !== 1'b0 || hs_grant !== 1'b0) begin n_fail++; $display("FAIL reset_release got pause=%b grant=%b expected 0 0", cpu_pause, hs_grant); end
   endtask

   task automatic prime_cpu(input logic [AW-1:0] a);
      next_cycle();
      cpu_address = a; cpu_cs = 1'b0; cpu_write = 1'b0;
      next_cycle();
      next_cycle();
      frozen_exp = ref_mem[a];
      n_checks++; if (cpu_rdata !== frozen_exp) begin n_fail++; $display("FAIL prime_cpu_rdata addr=%h got %h expected %h", a, cpu_rdata, frozen_exp); end
   endtask

   // Ends in the first cycle of engine ownership; idle_at <= 0 means cpu_idle never comes
   task automatic do_handover(input int idle_at, input bit pulse, input logic [AW-1:0] hold_addr);
      int g;
      g = (idle_at > 0) ? idle_at + 1 + SETTLE : 1 + TMO + SETTLE;
      next_cycle();
      hs_pause_req = 1'b1; cpu_idle = 1'b0; cpu_cs = 1'b0; cpu_write = 1'b0;
      #1;
      n_checks++; if (cpu_pause !== 1'b0 || hs_grant !== 1'b0) begin n_fail++; $display("FAIL handover_c0 got pause=%b grant=%b expected 0 0", cpu_pause, hs_grant); end
      for (int c = 1; c <= g; c++) begin
         next_cycle();
         cpu_address = hold_addr;
         cpu_idle = (idle_at > 0) && (pulse ? (c == idle_at) : (c >= idle_at));
         #1;
         n_checks++; if (cpu_pause !== 1'b1) begin n_fail++; $display("FAIL handover_cpu_pause c=%0d got %b expected 1", c, cpu_pause); end
         n_checks++; if (hs_grant !== (c >= g)) begin n_fail++; $display("FAIL handover_grant c=%0d got %b expected %b", c, hs_grant, (c >= g)); end
         n_checks++; if (ram_write !== 1'b0) begin n_fail++; $display("FAIL handover_ram_write c=%0d got %b expected 0", c, ram_write); end
         n_checks++; if (cpu_rdata !== frozen_exp) begin n_fail++; $display("FAIL handover_cpu_rdata_frozen c=%0d got %h expected %h", c, cpu_rdata, frozen_exp); end
`ifdef HISCORE_MUX_TIMEOUT_EN
         if (idle_at <= 0 && c == TMO + 1) tmo_seen = 1'b1;
         n_checks++; if (hs_timeout !== tmo_seen) begin n_fail++; $display("FAIL handover_timeout c=%0d got %b expected %b", c, hs_timeout, tmo_seen); end
`endif
      end
   endtask

   task automatic do_release();
      next_cycle();
      hs_pause_req = 1'b0; hs_write = 1'b0;
      #1;
      n_checks++; if (hs_grant !== 1'b1) begin n_fail++; $display("FAIL release_last_own got grant=%b expected 1", hs_grant); end
      next_cycle();
      #1;
      n_checks++; if ({hs_grant, cpu_pause} !== 2'b01) begin n_fail++; $display("FAIL release_cycle got grant,pause=%b expected 01", {hs_grant, cpu_pause}); end
      next_cycle();
      cpu_idle = 1'b0;
      #1;
      n_checks++; if (cpu_pause !== 1'b0) begin n_fail++; $display("FAIL release_back_to_cpu got pause=%b expected 0", cpu_pause); end
   endtask

   task automatic test_handover();
      prime_cpu(10'h100);
      do_handover(3, 1'b0, 10'h101);
   endtask

   task automatic test_engine_read();
      next_cycle();
      hs_address = 10'h044;
      next_cycle();
      hs_address = 10'h043;
      next_cycle();
      hs_address = 10'h0AA;
      #1;
      n_checks++; if (hs_rdata !== 8'h11) begin n_fail++; $display("FAIL engine_read_lat1 got %h expected 11", hs_rdata); end
      next_cycle();
      #1;
      n_checks++; if (hs_rdata !== 8'h5A) begin n_fail++; $display("FAIL engine_read_lat2 got %h expected 5a", hs_rdata); end
      n_checks++; if (cpu_rdata !== frozen_exp) begin n_fail++; $display("FAIL engine_read_cpu_rdata got %h expected %h", cpu_rdata, frozen_exp); end
   endtask

   task automatic test_engine_traffic();
      logic [AW-1:0] a;
      logic          we;
      for (int t = 0; t < 40; t++) begin
         next_cycle();
         a = AW'($urandom_range(0, 1022));
         we = ($urandom_range(0, 2) == 0);
         hs_address = a; hs_write = we; hs_wdata = DW'($urandom);
         rd_exp[t] = ref_mem[a];
         if (we) ref_mem[a] = hs_wdata;
         #1;
         n_checks++; if (ram_write !== we || ram_address !== a) begin n_fail++; $display("FAIL engine_traffic_port t=%0d got we=%b addr=%h expected we=%b addr=%h", t, ram_write, ram_address, we, a); end
         if (t >= 2) begin
            n_checks++; if (hs_rdata !== rd_exp[t-2]) begin n_fail++; $display("FAIL engine_traffic_rdata t=%0d got %h expected %h", t, hs_rdata, rd_exp[t-2]); end
         end
         n_checks++; if (cpu_rdata !== frozen_exp || hs_grant !== 1'b1) begin n_fail++; $display("FAIL engine_traffic_hold t=%0d got cpu_rdata=%h grant=%b expected %h 1", t, cpu_rdata, hs_grant, frozen_exp); end
      end
   endtask

   task automatic test_write_release();
      logic [DW-1:0] cw;
      cw = DW'($urandom);
      next_cycle();
      hs_address = 10'h3FF; hs_wdata = 8'hA5; hs_write = 1'b1; hs_pause_req = 1'b0;
      cpu_cs = 1'b1; cpu_write = 1'b1; cpu_address = 10'h200; cpu_wdata = cw;
      ref_mem[10'h3FF] = 8'hA5;
      #1;
      n_checks++; if (ram_write !== 1'b1 || ram_address !== 10'h3FF || ram_wdata !== 8'hA5) begin n_fail++; $display("FAIL write_release_issue got we=%b addr=%h data=%h expected 1 3ff a5", ram_write, ram_address, ram_wdata); end
      next_cycle();
      hs_write = 1'b0; hs_pause_req = 1'b1; cpu_idle = 1'b0;
      #1;
      n_checks++; if (ram_write !== 1'b0 || ram_address !== 10'h200) begin n_fail++; $display("FAIL write_release_quiet got we=%b addr=%h expected 0 200", ram_write, ram_address); end
      n_checks++; if ({hs_grant, cpu_pause} !== 2'b01) begin n_fail++; $display("FAIL write_release_flags got grant,pause=%b expected 01", {hs_grant, cpu_pause}); end
      next_cycle();
      ref_mem[10'h200] = cw;
      #1;
      n_checks++; if ({hs_grant, cpu_pause, ram_write} !== 3'b001 || ram_address !== 10'h200) begin n_fail++; $display("FAIL back_to_back_cpu_own got grant,pause,we=%b addr=%h expected 001 200", {hs_grant, cpu_pause, ram_write}, ram_address); end
      next_cycle();
      cpu_cs = 1'b0; cpu_write = 1'b0; hs_pause_req = 1'b0;
      #1;
      n_checks++; if ({hs_grant, cpu_pause} !== 2'b01) begin n_fail++; $display("FAIL back_to_back_repause got grant,pause=%b expected 01", {hs_grant, cpu_pause}); end
      next_cycle();
      #1;
      n_checks++; if ({cpu_pause, hs_write_dropped} !== 2'b00) begin n_fail++; $display("FAIL back_to_back_abort got pause,dropped=%b expected 00", {cpu_pause, hs_write_dropped}); end
   endtask

   task automatic test_cpu_traffic();
      logic [AW-1:0] a;
      logic          cs, wr;
      for (int t = 0; t < 30; t++) begin
         next_cycle();
         a = AW'($urandom_range(0, 1022));
         cs = ($urandom_range(0, 3) != 0);
         wr = $urandom_range(0, 1) != 0;
         cpu_address = a; cpu_cs = cs; cpu_write = wr; cpu_wdata = DW'($urandom);
         rd_exp[t] = ref_mem[a];
         if (cs && wr) ref_mem[a] = cpu_wdata;
         #1;
         n_checks++; if (ram_write !== (cs && wr) || ram_address !== a || cpu_pause !== 1'b0) begin n_fail++; $display("FAIL cpu_traffic_port t=%0d got we=%b addr=%h pause=%b expected %b %h 0", t, ram_write, ram_address, cpu_pause, (cs && wr), a); end
         if (t >= 2) begin
            n_checks++; if (cpu_rdata !== rd_exp[t-2]) begin n_fail++; $display("FAIL cpu_traffic_rdata t=%0d got %h expected %h", t, cpu_rdata, rd_exp[t-2]); end
         end
      end
      next_cycle();
      cpu_cs = 1'b0; cpu_write = 1'b0;
   endtask

   task automatic test_abort();
      next_cycle();
      hs_pause_req = 1'b1; cpu_idle = 1'b0;
      next_cycle();
      #1;
      n_checks++; if ({cpu_pause, hs_grant} !== 2'b10) begin n_fail++; $display("FAIL abort_pause got pause,grant=%b expected 10", {cpu_pause, hs_grant}); end
      next_cycle();
      hs_pause_req = 1'b0; hs_write = 1'b1; hs_address = 10'h055;
      #1;
      n_checks++; if (ram_write !== 1'b0 || hs_write_dropped !== 1'b0) begin n_fail++; $display("FAIL abort_stray_write got we=%b dropped=%b expected 0 0", ram_write, hs_write_dropped); end
      for (int c = 3; c < 6; c++) begin
         next_cycle();
         hs_write = 1'b0;
         #1;
         n_checks++; if ({cpu_pause, hs_grant, hs_write_dropped} !== 3'b001) begin n_fail++; $display("FAIL abort_after c=%0d got pause,grant,dropped=%b expected 001", c, {cpu_pause, hs_grant, hs_write_dropped}); end
      end
   endtask

   task automatic test_random_handover();
      logic [AW-1:0] a;
      for (int k = 0; k < 6; k++) begin
         a = AW'($urandom_range(0, 1023));
         prime_cpu(a);
         do_handover(int'($urandom_range(1, 6)), 1'b1, a ^ 10'h155);
         do_release();
      end
   endtask

`ifdef HISCORE_MUX_TIMEOUT_EN
   task automatic test_timeout();
      prime_cpu(10'h0F0);
      do_handover(0, 1'b0, 10'h0F1);
      do_release();
      n_checks++; if (hs_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky got %b expected 1", hs_timeout); end
   endtask
`else
   task automatic test_no_timeout();
      next_cycle();
      hs_pause_req = 1'b1; cpu_idle = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         next_cycle();
         #1;
         n_checks++; if ({cpu_pause, hs_grant} !== 2'b10) begin n_fail++; $display("FAIL no_timeout_wait c=%0d got pause,grant=%b expected 10", c, {cpu_pause, hs_grant}); end
      end
      hs_pause_req = 1'b0;
      next_cycle();
      #1;
      n_checks++; if (cpu_pause !== 1'b0) begin n_fail++; $display("FAIL no_timeout_abort got pause=%b expected 0", cpu_pause); end
   endtask
`endif

   task automatic test_reset_mid_write();
      prime_cpu(10'h0C0);
      do_handover(2, 1'b0, 10'h0C0);
      next_cycle();
      hs_write = 1'b1; hs_address = 10'h0C7; hs_wdata = 8'h3C;
      #1;
      n_checks++; if (ram_write !== 1'b1) begin n_fail++; $display("FAIL reset_mid_write_pre got we=%b expected 1", ram_write); end
      #2;
      reset = 1'b1;
      #1;
      n_checks++; if ({ram_write, hs_grant, cpu_pause, hs_write_dropped} !== 4'b0000) begin n_fail++; $display("FAIL reset_mid_write_flags got we,grant,pause,dropped=%b expected 0000", {ram_write, hs_grant, cpu_pause, hs_write_dropped}); end
      n_checks++; if (hs_rdata !== 8'h00 || cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_mid_write_rdata got %h/%h expected 00/00", hs_rdata, cpu_rdata); end
      tmo_seen = 1'b0;
`ifdef HISCORE_MUX_TIMEOUT_EN
      n_checks++; if (hs_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_mid_write_timeout got %b expected 0", hs_timeout); end
`endif
      hs_write = 1'b0; hs_pause_req = 1'b0; cpu_idle = 1'b0;
      next_cycle();
      reset = 1'b0;
      next_cycle();
      n_checks++; if ({cpu_pause, hs_grant} !== 2'b00) begin n_fail++; $display("FAIL reset_mid_write_after got pause,grant=%b expected 00", {cpu_pause, hs_grant}); end
   endtask

   task automatic test_mem_image();
      int bad;
      next_cycle();
      next_cycle();
      bad = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL mem_image got %0d differing bytes expected 0", bad); end
   endtask

   initial begin
      test_reset();
      test_handover();
      test_engine_read();
      test_engine_traffic();
      test_write_release();
      test_cpu_traffic();
      test_abort();
      test_random_handover();
`ifdef HISCORE_MUX_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_reset_mid_write();
      test_mem_image();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_time_limit got no finish expected finish before 1000000");
      $fatal(1, "time limit");
   end
endmodule

// File: doc/hiscore_ram_mux.md
Name: hiscore_ram_mux

Overview:
- Downstream of the hiscore engine. Arbitrates the game's work-RAM port between the game CPU and the hiscore engine.
- Turns the engine's pause request into a handshaked CPU halt and waits for the bus to settle before handing over the port.
- Returns read data to the engine, which reaches it via the ioctl_din path.
- Returns ownership to the CPU cleanly and freezes the CPU's read data while the CPU is halted.

Parameters:
- ADDRESSWIDTH, 10, width of the game RAM address.
- DATAWIDTH, 8, RAM data width.
- SETTLE_CYCLES, 2, cycles between halt acknowledge and grant (range 1..15).
- TIMEOUT_CYCLES, 65535, halt-ack watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- hs_pause_req  in  1  engine pause (hiscore `pause` output).
- hs_address  in  ADDRESSWIDTH  engine RAM address.
- hs_wdata  in  DATAWIDTH  engine write data.
- hs_write  in  1  engine write strobe, active high.
- hs_rdata  out  DATAWIDTH  registered RAM read data to the engine.
- hs_grant  out  1  engine owns the RAM port.
- hs_write_dropped  out  1  sticky: hs_write was seen while not granted.
- cpu_address  in  ADDRESSWIDTH  CPU RAM address.
- cpu_wdata  in  DATAWIDTH  CPU write data.
- cpu_cs  in  1  CPU RAM select.
- cpu_write  in  1  CPU write strobe.
- cpu_idle  in  1  CPU reports halted with the bus released.
- cpu_pause  out  1  halt request to the CPU core.
- cpu_rdata  out  DATAWIDTH  read data to the CPU.
- ram_address  out  ADDRESSWIDTH  muxed RAM address.
- ram_wdata  out  DATAWIDTH  muxed RAM write data.
- ram_write  out  1  muxed RAM write enable.
- ram_rdata  in  DATAWIDTH  RAM read data, one cycle after the address.

Behaviour:
- Reset (asynchronous) gives: state CPU_OWN, cpu_pause=0, hs_grant=0, hs_rdata=0, cpu_rdata=0, hs_write_dropped=0, settle counter 0. ram_write follows CPU_OWN muxing.
- State machine (registered, one state per cycle; each state's outputs below):
  - CPU_OWN: cpu_pause=0. RAM mux selects the CPU; ram_write = cpu_cs & cpu_write. cpu_rdata <= ram_rdata every cycle. hs_pause_req=1 -> PAUSE_WAIT.
  - PAUSE_WAIT: cpu_pause=1; mux still on the CPU. hs_pause_req=0 -> CPU_OWN (abort). cpu_idle=1 -> SETTLE, counter <= SETTLE_CYCLES-1.
  - SETTLE: cpu_pause=1. ram_write=0; mux selects the engine address. Counter decrements each cycle; at 0 -> HS_OWN. hs_pause_req=0 -> RELEASE.
  - HS_OWN: hs_grant=1, cpu_pause=1. ram_address=hs_address, ram_wdata=hs_wdata, ram_write=hs_write. hs_rdata <= ram_rdata every cycle, so read latency from hs_address to hs_rdata is 2 cycles. hs_pause_req=0 -> RELEASE; a write asserted in that same cycle is still issued.
  - RELEASE: one cycle with ram_write=0, hs_grant=0, cpu_pause=1, mux on the CPU address. Then -> CPU_OWN.
- hs_grant and cpu_pause are registered outputs decoded from the next state.
- cpu_rdata is frozen outside CPU_OWN, so the halted CPU sees a stable value.
- hs_write=1 in any state other than HS_OWN: write suppressed, hs_write_dropped set. The flag clears only on reset.
- cpu_idle dropping during SETTLE or HS_OWN is ignored; the CPU must stay halted while cpu_pause=1.
- hs_pause_req re-asserted during RELEASE is sampled in CPU_OWN on the next cycle. No back-to-back grant without passing through CPU_OWN.
- Reset during HS_OWN: ram_write drops immediately (asynchronously); the port returns to the CPU.

Optional Feature:
- Macro: HISCORE_MUX_TIMEOUT_EN.
- Defined: a 16-bit watchdog runs in PAUSE_WAIT. If cpu_idle is still absent after TIMEOUT_CYCLES cycles, go -> SETTLE anyway and set sticky output hs_timeout (extra 1-bit port, cleared by reset). The counter resets on every entry to PAUSE_WAIT.
- Undefined: PAUSE_WAIT waits indefinitely; no hs_timeout port; no watchdog logic.

Decomposition:
- Shared package hiscore_pkg:
  - mux_state_t enum {CPU_OWN, PAUSE_WAIT, SETTLE, HS_OWN, RELEASE} (3-bit).
  - SETTLE_W=4, TIMEOUT_W=16.
  - The hiscore ioctl index constants (config=3, dump=4) also live here for shared use with the engine.
- One natural sub-module: hs_down_counter (load / decrement / zero flag), instantiated for the settle counter and, when enabled, the watchdog.

Test Plan:
- Pause handover: hs_pause_req rises at cycle 0, cpu_idle rises at cycle 3, SETTLE_CYCLES=2 -> cpu_pause=1 from cycle 1; hs_grant=1 from cycle 6; no ram_write between cycles 1 and 6.
- Engine read: in HS_OWN, hs_address=0x043, RAM holds 0x5A -> hs_rdata=0x5A exactly 2 cycles later; cpu_rdata unchanged throughout.
- Engine write then release: hs_write=1 with hs_address=0x3FF, hs_wdata=0xA5, and hs_pause_req falls in the same cycle -> RAM[0x3FF]=0xA5; one RELEASE cycle with ram_write=0; CPU owns the port the next cycle.
- Aborted pause: hs_pause_req pulses for 2 cycles with cpu_idle=0 -> returns to CPU_OWN, cpu_pause falls, hs_grant never asserts; a stray hs_write sets hs_write_dropped=1.
- Reset mid-write: reset asserted during HS_OWN with hs_write=1 -> ram_write=0 and hs_grant=0 in the same cycle, all flags cleared.
- (HISCORE_MUX_TIMEOUT_EN, TIMEOUT_CYCLES=16) cpu_idle held 0 -> hs_timeout=1 after 16 cycles in PAUSE_WAIT; hs_grant follows after SETTLE.
